// File: rtl/arm7tdmi_mul_sequencer.sv
// Multiply sequencer: counts Rs-dependent CALC cycles, latches the multiplier
// result, then writes lo (and hi for long ops) back with optional N/Z update.
module arm7tdmi_mul_sequencer #(
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mul_type,
  input  logic        mul_signed,
  input  logic        set_flags,
  input  logic [31:0] rs_value,
  input  logic [3:0]  rd_lo_idx,
  input  logic [3:0]  rd_hi_idx,
  input  logic        flush,
  input  logic [31:0] result_hi,
  input  logic [31:0] result_lo,
  output logic        mul_en,
  output logic        busy,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        flag_we,
  output logic        flag_n,
  output logic        flag_z,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [1:0]  type_q;
  logic        sflag_q;
  logic [3:0]  rd_lo_q, rd_hi_q;
  logic [31:0] lo_q, hi_q;
  logic        accept_ones;
  logic [2:0]  m_val, c_val;
  logic        long_op, last_wb;

  // mul_signed only matters when choosing m, so it is consumed at acceptance.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    m_val       = 3'd4;
    accept_ones = !(mul_type[1] && !mul_signed);
    if (EARLY_TERM) begin
      if (rs_value[31:8] == '0 || (accept_ones && &rs_value[31:8]))
        m_val = 3'd1;
      else if (rs_value[31:16] == '0 || (accept_ones && &rs_value[31:16]))
        m_val = 3'd2;
      else if (rs_value[31:24] == '0 || (accept_ones && &rs_value[31:24]))
        m_val = 3'd3;
    end
    case (mul_type)
      2'b00:   c_val = m_val;
      2'b11:   c_val = m_val + 3'd2;
      default: c_val = m_val + 3'd1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !flush) state_nxt = CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == 3'd1) state_nxt = WB_LO;
      WB_LO:   state_nxt = (flush || !long_op) ? IDLE : WB_HI;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: operand latches are reset as well, so nothing stale survives rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      type_q  <= '0;
      sflag_q <= 1'b0;
      rd_lo_q <= '0;
      rd_hi_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      if (state == IDLE && start && !flush) begin
        cnt     <= c_val;
        type_q  <= mul_type;
        sflag_q <= set_flags;
        rd_lo_q <= rd_lo_idx;
        rd_hi_q <= rd_hi_idx;
      end else if (state == CALC && !flush) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          lo_q <= result_lo;
          hi_q <= result_hi;
        end
      end
    end
  end

  assign long_op = type_q[1];
  assign last_wb = (state == WB_HI) || (state == WB_LO && !long_op);

  // Flush suppresses writes combinationally in the cycle it is seen.
  always_comb begin
    busy    = (state != IDLE);
    mul_en  = (state == CALC);
    wb_en   = (state == WB_LO || state == WB_HI) && !flush;
    wb_addr = '0;
    wb_data = '0;
    if (wb_en) begin
      wb_addr = (state == WB_HI) ? rd_hi_q : rd_lo_q;
      wb_data = (state == WB_HI) ? hi_q : lo_q;
    end
    done    = last_wb && !flush;
    flag_we = done && sflag_q;
    flag_n  = 1'b0;
    flag_z  = 1'b0;
    if (flag_we) begin
      flag_n = long_op ? hi_q[31] : lo_q[31];
      flag_z = long_op ? ({hi_q, lo_q} == 64'd0) : (lo_q == 32'd0);
    end
  end

endmodule

// File: tb/tb_arm7tdmi_mul_sequencer.sv
// Directed bench for arm7tdmi_mul_sequencer: vector table of complete
// multiplies plus hand sequences for flush, reset and EARLY_TERM=0.
module tb_arm7tdmi_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, mul_signed, set_flags, flush;
  logic [1:0]  mul_type;
  logic [31:0] rs_value, result_hi, result_lo;
  logic [3:0]  rd_lo_idx, rd_hi_idx;

  logic        mul_en1, busy1, wb_en1, flag_we1, flag_n1, flag_z1, done1;
  logic [3:0]  wb_addr1;
  logic [31:0] wb_data1;
  logic        mul_en0, busy0, wb_en0, flag_we0, flag_n0, flag_z0, done0;
  logic [3:0]  wb_addr0;
  logic [31:0] wb_data0;

  logic        use0 = 1'b0;
  logic        o_mul_en, o_busy, o_wb_en, o_flag_we, o_flag_n, o_flag_z, o_done;
  logic [3:0]  o_wb_addr;
  logic [31:0] o_wb_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arm7tdmi_mul_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mul_type(mul_type), .mul_signed(mul_signed),
    .set_flags(set_flags), .rs_value(rs_value), .rd_lo_idx(rd_lo_idx), .rd_hi_idx(rd_hi_idx),
    .flush(flush), .result_hi(result_hi), .result_lo(result_lo), .mul_en(mul_en1),
    .busy(busy1), .wb_en(wb_en1), .wb_addr(wb_addr1), .wb_data(wb_data1),
    .flag_we(flag_we1), .flag_n(flag_n1), .flag_z(flag_z1), .done(done1)
  );

  arm7tdmi_mul_sequencer #(.EARLY_TERM(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mul_type(mul_type), .mul_signed(mul_signed),
    .set_flags(set_flags), .rs_value(rs_value), .rd_lo_idx(rd_lo_idx), .rd_hi_idx(rd_hi_idx),
    .flush(flush), .result_hi(result_hi), .result_lo(result_lo), .mul_en(mul_en0),
    .busy(busy0), .wb_en(wb_en0), .wb_addr(wb_addr0), .wb_data(wb_data0),
    .flag_we(flag_we0), .flag_n(flag_n0), .flag_z(flag_z0), .done(done0)
  );

  assign o_mul_en  = use0 ? mul_en0  : mul_en1;
  assign o_busy    = use0 ? busy0    : busy1;
  assign o_wb_en   = use0 ? wb_en0   : wb_en1;
  assign o_wb_addr = use0 ? wb_addr0 : wb_addr1;
  assign o_wb_data = use0 ? wb_data0 : wb_data1;
  assign o_flag_we = use0 ? flag_we0 : flag_we1;
  assign o_flag_n  = use0 ? flag_n0  : flag_n1;
  assign o_flag_z  = use0 ? flag_z0  : flag_z1;
  assign o_done    = use0 ? done0    : done1;

  typedef struct {
    logic [1:0]  typ;
    logic        sgn;
    logic        s;
    logic [31:0] rs;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  rdl;
    logic [3:0]  rdh;
    int          c;
    logic        n;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},    {31'd0, o_busy},    32'd0);
    check({tag, "_mul_en"},  {31'd0, o_mul_en},  32'd0);
    check({tag, "_wb_en"},   {31'd0, o_wb_en},   32'd0);
    check({tag, "_wb_addr"}, {28'd0, o_wb_addr}, 32'd0);
    check({tag, "_wb_data"}, o_wb_data,          32'd0);
    check({tag, "_flag_we"}, {31'd0, o_flag_we}, 32'd0);
    check({tag, "_flags"},   {30'd0, o_flag_n, o_flag_z}, 32'd0);
    check({tag, "_done"},    {31'd0, o_done},    32'd0);
  endtask

  // Full multiply: CALC length, latched writeback data/addresses, flags, return to IDLE.
  task automatic do_op(input vec_t v, input logic obs0, input string tag);
    int  n;
    logic lng, fin_lo;
    use0 = obs0;
    lng = v.typ[1];
    fin_lo = !lng;
    @(negedge clk);
    mul_type = v.typ; mul_signed = v.sgn; set_flags = v.s; rs_value = v.rs;
    result_lo = v.lo; result_hi = v.hi; rd_lo_idx = v.rdl; rd_hi_idx = v.rdh;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs that must have been latched at acceptance.
    rd_lo_idx = ~v.rdl; rd_hi_idx = ~v.rdh; mul_type = ~v.typ; set_flags = ~v.s;
    n = 0;
    while (o_mul_en && n < 8) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_calc_cycles"}, n, v.c);
    result_lo = ~v.lo; result_hi = ~v.hi;
    check({tag, "_lo_busy"},    {31'd0, o_busy},    32'd1);
    check({tag, "_lo_wb_en"},   {31'd0, o_wb_en},   32'd1);
    check({tag, "_lo_wb_addr"}, {28'd0, o_wb_addr}, {28'd0, v.rdl});
    check({tag, "_lo_wb_data"}, o_wb_data,          v.lo);
    check({tag, "_lo_done"},    {31'd0, o_done},    {31'd0, fin_lo});
    check({tag, "_lo_flag_we"}, {31'd0, o_flag_we}, {31'd0, fin_lo & v.s});
    check({tag, "_lo_flags"},   {30'd0, o_flag_n, o_flag_z},
          {30'd0, fin_lo & v.s & v.n, fin_lo & v.s & v.z});
    if (lng) begin
      @(negedge clk);
      check({tag, "_hi_wb_en"},   {31'd0, o_wb_en},   32'd1);
      check({tag, "_hi_wb_addr"}, {28'd0, o_wb_addr}, {28'd0, v.rdh});
      check({tag, "_hi_wb_data"}, o_wb_data,          v.hi);
      check({tag, "_hi_done"},    {31'd0, o_done},    32'd1);
      check({tag, "_hi_flag_we"}, {31'd0, o_flag_we}, {31'd0, v.s});
      check({tag, "_hi_flags"},   {30'd0, o_flag_n, o_flag_z}, {30'd0, v.s & v.n, v.s & v.z});
    end
    @(negedge clk);
    check({tag, "_end_busy"},  {31'd0, o_busy},  32'd0);
    check({tag, "_end_wb_en"}, {31'd0, o_wb_en}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; flush = 1'b0; mul_type = 2'b00; mul_signed = 1'b0;
    set_flags = 1'b0; rs_value = '0; result_hi = '0; result_lo = '0;
    rd_lo_idx = '0; rd_hi_idx = '0;

    //          typ    sgn   s     rs            lo            hi            rdl    rdh    c  n     z
    vecs[0] = '{2'b00, 1'b0, 1'b0, 32'h0000_00FF, 32'h1234_5678, 32'h0000_0000, 4'd3,  4'd0,  1, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 4'd4,  4'd5,  6, 1'b1, 1'b0};
    vecs[2] = '{2'b10, 1'b1, 1'b1, 32'hFFFF_FF80, 32'hDEAD_BEEF, 32'h0000_0001, 4'd1,  4'd2,  2, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 1'b0, 1'b1, 32'hFFFF_FF80, 32'h0000_0000, 32'h0000_0000, 4'd6,  4'd7,  5, 1'b0, 1'b1};
    vecs[4] = '{2'b00, 1'b0, 1'b1, 32'hFFFF_FF80, 32'h8000_0000, 32'h0000_0000, 4'd8,  4'd0,  1, 1'b1, 1'b0};
    vecs[5] = '{2'b01, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 4'd9,  4'd0,  3, 1'b0, 1'b1};
    vecs[6] = '{2'b11, 1'b1, 1'b1, 32'h00FF_0000, 32'h0000_0001, 32'h0000_0000, 4'd10, 4'd10, 5, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'hCAFE_F00D, 32'h1357_9BDF, 4'd11, 4'd12, 5, 1'b0, 1'b0};
    vecs[8] = '{2'b01, 1'b0, 1'b1, 32'hFFFF_8000, 32'h0000_0000, 32'hFFFF_FFFF, 4'd13, 4'd0,  3, 1'b0, 1'b1};
    vecs[9] = '{2'b11, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 4'd14, 4'd15, 3, 1'b0, 1'b0};

    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i], 1'b0, $sformatf("vec%0d", i));
      pulse_reset();  // keep the EARLY_TERM=0 instance aligned
    end

    // EARLY_TERM=0: MLA with rs=0 still takes m=4, C=5; zero result sets Z.
    do_op('{2'b01, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4'd2, 4'd0, 5, 1'b0, 1'b1}, 1'b1, "noet_mla");
    pulse_reset();
    use0 = 1'b0;

    // flush and start together in IDLE: start dropped.
    @(negedge clk);
    mul_type = 2'b00; rs_value = 32'h0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_start_busy", {31'd0, busy1}, 32'd0);

    // UMULL C=5: start held during busy (ignored), flush in CALC cycle 2.
    @(negedge clk);
    mul_type = 2'b10; mul_signed = 1'b0; set_flags = 1'b1; rs_value = 32'hFFFF_FF80;
    rd_lo_idx = 4'd1; rd_hi_idx = 4'd2; start = 1'b1;
    @(negedge clk);
    check("flush_c1_mul_en", {31'd0, mul_en1}, 32'd1);
    mul_type = 2'b00; rs_value = 32'h0;
    @(negedge clk);
    check("flush_c2_mul_en", {31'd0, mul_en1}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_idle_busy", {31'd0, busy1}, 32'd0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy1 || wb_en1 || done1 || flag_we1) n++;
      @(negedge clk);
    end
    check("flush_no_activity_after", n, 0);

    // flush during WB_LO of a MUL suppresses write, done and flags in that cycle.
    @(negedge clk);
    mul_type = 2'b00; set_flags = 1'b1; rs_value = 32'h0; result_lo = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("wbflush_wb_en", {31'd0, wb_en1}, 32'd0);
    check("wbflush_done_flag_we", {30'd0, done1, flag_we1}, 32'd0);
    check("wbflush_wb_data", wb_data1, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    check("wbflush_idle", {31'd0, busy1}, 32'd0);

    // rst pulse during WB_LO of UMULL: outputs drop at once, no WB_HI.
    pulse_reset();
    @(negedge clk);
    mul_type = 2'b10; mul_signed = 1'b0; set_flags = 1'b1; rs_value = 32'h0;
    result_lo = 32'h1111_1111; result_hi = 32'h2222_2222; rd_lo_idx = 4'd3; rd_hi_idx = 4'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!wb_en1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("rst_reach_wb_lo", {31'd0, wb_en1}, 32'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_wb_hi", {30'd0, wb_en1, busy1}, 32'd0);
    do_op(vecs[3], 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
